// File: rtl/clock_pkg.sv
// Shared types, limits and the BCD increment helper for the time-of-day counter.
package clock_pkg;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd2_t;

  typedef struct packed {
    bcd2_t value;
    logic  wrap;
  } bcd_step_t;

  localparam bcd2_t SEC_MAX = 8'h59;
  localparam bcd2_t MIN_MAX = 8'h59;
  localparam bcd2_t HR_MAX  = 8'h23;

  // Next BCD value modulo (max_v + 1); wrap flags the return to 00.
  function automatic bcd_step_t bcd_inc(input bcd2_t value, input bcd2_t max_v);
    bcd_step_t r;
    if (value == max_v) begin
      r.value = 8'h00;
      r.wrap  = 1'b1;
    end else if (value.units == 4'd9) begin
      r.value.tens  = value.tens + 4'd1;
      r.value.units = 4'd0;
      r.wrap        = 1'b0;
    end else begin
      r.value.tens  = value.tens;
      r.value.units = value.units + 4'd1;
      r.wrap        = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit packed-BCD counter that wraps after MAX; clear has priority over increment.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter bcd2_t MAX = SEC_MAX
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  output logic [7:0] q,
  output logic       wrap
);

  bcd2_t     q_r;
  bcd_step_t step_s;

  // Candidate next value from the current count.
  always_comb begin
    step_s = bcd_inc(q_r, MAX);
  end

  assign wrap = inc & step_s.wrap;
  assign q    = q_r;

  // Count register.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= 8'h00;
    end else if (clr) begin
      q_r <= 8'h00;
    end else if (inc) begin
      q_r <= step_s.value;
    end else begin
      q_r <= q_r;
    end
  end

endmodule

// File: rtl/time_of_day_counter.sv
// 24-hour BCD wall clock advanced by synchronised rising edges of a slow square wave.
module time_of_day_counter
  import clock_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 4
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       slow_clk,
  input  logic       run,
  input  logic       inc_min,
  input  logic       inc_hr,
  input  logic       clr_sec,
  output logic [7:0] hours_bcd,
  output logic [7:0] minutes_bcd,
  output logic [7:0] seconds_bcd,
  output logic       sec_pulse,
  output logic       colon_blink
);

  localparam logic [7:0] TPS_LAST = 8'(TICKS_PER_SEC - 1);
  localparam logic [7:0] TPS_HALF = 8'(TICKS_PER_SEC / 2);

  logic       s1_r, s2_r, s3_r;
  logic [7:0] presc_r;
  logic [7:0] presc_next_s;
  logic       sec_pulse_r, colon_blink_r;
  logic       tick_s, adv_s, presc_last_s, sec_inc_s;
  logic       sec_wrap_s, min_wrap_s, min_inc_s, min_carry_s, hr_inc_s;

  // Two-flop synchroniser plus history flop for rising-edge detection.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= slow_clk;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  // Prescaler and carry/set arbitration.
  always_comb begin
    tick_s       = s2_r & ~s3_r;
    adv_s        = tick_s & run;
    presc_last_s = (presc_r == TPS_LAST);
    sec_inc_s    = adv_s & presc_last_s & ~clr_sec;
    if (clr_sec) begin
      presc_next_s = 8'd0;
    end else if (adv_s && presc_last_s) begin
      presc_next_s = 8'd0;
    end else if (adv_s) begin
      presc_next_s = presc_r + 8'd1;
    end else begin
      presc_next_s = presc_r;
    end
    // A set pulse coinciding with a carry still moves the field by one.
    min_inc_s   = sec_wrap_s | inc_min;
    min_carry_s = sec_wrap_s & min_wrap_s;
    hr_inc_s    = min_carry_s | inc_hr;
  end

  // Prescaler, second strobe and colon phase.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      presc_r       <= 8'd0;
      sec_pulse_r   <= 1'b0;
      colon_blink_r <= 1'b1;
    end else begin
      presc_r       <= presc_next_s;
      sec_pulse_r   <= sec_inc_s;
      colon_blink_r <= (presc_next_s < TPS_HALF);
    end
  end

  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .inc    (sec_inc_s),
    .clr    (clr_sec),
    .q      (seconds_bcd),
    .wrap   (sec_wrap_s)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .inc    (min_inc_s),
    .clr    (1'b0),
    .q      (minutes_bcd),
    .wrap   (min_wrap_s)
  );

  bcd_mod_counter #(.MAX(HR_MAX)) u_hr (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .inc    (hr_inc_s),
    .clr    (1'b0),
    .q      (hours_bcd),
    .wrap   ()
  );

  assign sec_pulse   = sec_pulse_r;
  assign colon_blink = colon_blink_r;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Directed bench for time_of_day_counter with hand-computed expectations.
`timescale 1ns/1ps
module tb_time_of_day_counter;

  logic       clk_in = 1'b0;
  logic       rst_n = 1'b0;
  logic       slow_clk = 1'b0;
  logic       run = 1'b0;
  logic       inc_min = 1'b0;
  logic       inc_hr = 1'b0;
  logic       clr_sec = 1'b0;
  logic [7:0] hours_bcd, minutes_bcd, seconds_bcd;
  logic       sec_pulse, colon_blink;

  int n_checks = 0;
  int n_errors = 0;

  time_of_day_counter #(.TICKS_PER_SEC(4)) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .slow_clk    (slow_clk),
    .run         (run),
    .inc_min     (inc_min),
    .inc_hr      (inc_hr),
    .clr_sec     (clr_sec),
    .hours_bcd   (hours_bcd),
    .minutes_bcd (minutes_bcd),
    .seconds_bcd (seconds_bcd),
    .sec_pulse   (sec_pulse),
    .colon_blink (colon_blink)
  );

  always #2.5 clk_in = ~clk_in;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_time(input string tag, input logic [23:0] exp);
    check(tag, {8'h00, hours_bcd, minutes_bcd, seconds_bcd}, {8'h00, exp});
  endtask

  // Rise: the update lands at the third clk edge after the negedge that drives it.
  task automatic rise();
    @(negedge clk_in);
    slow_clk = 1'b1;
    repeat (3) @(negedge clk_in);
  endtask

  task automatic fall();
    slow_clk = 1'b0;
    repeat (3) @(negedge clk_in);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      rise();
      fall();
    end
  endtask

  task automatic press(input logic m, input logic h, input logic c, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      inc_min = m; inc_hr = h; clr_sec = c;
      @(negedge clk_in);
      inc_min = 1'b0; inc_hr = 1'b0; clr_sec = 1'b0;
    end
  endtask

  // Rise with a set pulse landing in the cycle the tick is high.
  task automatic rise_with(input logic m, input logic c);
    @(negedge clk_in);
    slow_clk = 1'b1;
    repeat (2) @(negedge clk_in);
    inc_min = m; clr_sec = c;
    @(negedge clk_in);
    inc_min = 1'b0; clr_sec = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk_in);
    check_time("reset_time", 24'h000000);
    check("reset_pulse", {31'd0, sec_pulse}, 32'd0);
    check("reset_colon", {31'd0, colon_blink}, 32'd1);

    // First second: colon phases and pulse width
    rst_n = 1'b1; run = 1'b1;
    rise(); check("colon_p1", {31'd0, colon_blink}, 32'd1); fall();
    rise(); check("colon_p2", {31'd0, colon_blink}, 32'd0); fall();
    rise(); check("colon_p3", {31'd0, colon_blink}, 32'd0);
    check_time("no_adv_p3", 24'h000000); fall();
    @(negedge clk_in);
    slow_clk = 1'b1;
    repeat (2) @(negedge clk_in);
    check("pulse_early", {31'd0, sec_pulse}, 32'd0);
    check_time("time_early", 24'h000000);
    @(negedge clk_in);
    check("pulse_on", {31'd0, sec_pulse}, 32'd1);
    check_time("first_sec", 24'h000001);
    check("colon_p0", {31'd0, colon_blink}, 32'd1);
    @(negedge clk_in);
    check("pulse_off", {31'd0, sec_pulse}, 32'd0);
    fall();

    // Day rollover
    press(1'b0, 1'b1, 1'b0, 23);
    press(1'b1, 1'b0, 1'b0, 59);
    ticks(232);
    check_time("preload_235959", 24'h235959);
    ticks(3);
    rise();
    check_time("rollover", 24'h000000);
    check("rollover_pulse", {31'd0, sec_pulse}, 32'd1);
    check("rollover_hours", {24'd0, hours_bcd}, 32'h00);
    fall();

    // inc_min coincident with seconds carry
    press(1'b0, 1'b1, 1'b0, 12);
    press(1'b1, 1'b0, 1'b0, 34);
    ticks(236);
    check_time("preload_123459", 24'h123459);
    ticks(3);
    rise_with(1'b1, 1'b0);
    check_time("inc_min_carry", 24'h123500);
    check("inc_min_carry_pulse", {31'd0, sec_pulse}, 32'd1);
    fall();

    // Frozen run: ticks discarded, set inputs act
    ticks(2);
    check("pre_freeze_colon", {31'd0, colon_blink}, 32'd0);
    run = 1'b0;
    ticks(10);
    check_time("frozen_time", 24'h123500);
    check("frozen_colon", {31'd0, colon_blink}, 32'd0);
    press(1'b0, 1'b1, 1'b0, 1);
    check_time("frozen_inc_hr", 24'h133500);
    run = 1'b1;
    ticks(1);
    check_time("thaw_p3", 24'h133500);
    rise();
    check_time("thaw_adv", 24'h133501);
    fall();

    // clr_sec coincident with the carrying tick
    @(negedge clk_in); rst_n = 1'b0;
    @(negedge clk_in); rst_n = 1'b1;
    ticks(28);
    check_time("at_000007", 24'h000007);
    ticks(3);
    rise_with(1'b0, 1'b1);
    check_time("clr_wins", 24'h000000);
    check("clr_no_pulse", {31'd0, sec_pulse}, 32'd0);
    check("clr_colon", {31'd0, colon_blink}, 32'd1);
    fall();
    ticks(3);
    check_time("clr_presc0", 24'h000000);
    ticks(1);
    check_time("clr_then_sec", 24'h000001);

    // Both set pulses together, then async reset between ticks
    press(1'b1, 1'b1, 1'b0, 5);
    press(1'b1, 1'b0, 1'b0, 1);
    check_time("both_set", 24'h050601);
    ticks(24);
    check_time("at_050607", 24'h050607);
    ticks(2);
    check("pre_rst_colon", {31'd0, colon_blink}, 32'd0);
    @(negedge clk_in);
    #1 rst_n = 1'b0;
    #1;
    check_time("async_rst_time", 24'h000000);
    check("async_rst_colon", {31'd0, colon_blink}, 32'd1);
    check("async_rst_pulse", {31'd0, sec_pulse}, 32'd0);
    @(negedge clk_in); rst_n = 1'b1;
    ticks(3);
    check_time("post_rst_p3", 24'h000000);
    ticks(1);
    check_time("post_rst_sec", 24'h000001);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
